// File: rtl/conv_channel_accumulator.sv
// Per-pixel channel accumulator placed after the 9-tap adder tree: sums IN_CHANNELS
// partial sums plus a filter bias, applies optional ReLU and holds the result for writeback.
module conv_channel_accumulator #(
    parameter int WIDTH       = 32,
    parameter int IN_CHANNELS = 3,
    parameter int OUT_PIXELS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adder_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] bias,
    input  logic             relu_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic             out_last,
    output logic             in_ready,
    output logic             overrun
);

    localparam int CW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int PW = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(IN_CHANNELS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(OUT_PIXELS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [PW-1:0]    r_pix;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_dout;
    logic             r_out_last;
    logic             r_overrun;

    logic             w_first;
    logic             w_last;
    logic             w_done;
    logic             w_can_load;
    logic             w_clip;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_result;

    // State register; r_state is IDLE exactly when r_count is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (adder_valid) begin
            if (r_count == C_LAST) begin
                w_state_next = S_IDLE;
            end else begin
                w_state_next = S_ACCUM;
            end
        end
    end

    always_comb begin
        w_first    = (r_state == S_IDLE);
        w_last     = (r_count == C_LAST);
        w_done     = adder_valid && w_last;
        w_can_load = !r_out_valid || out_ready;
    end

    assign w_sum  = (w_first ? bias : r_acc) + din;
    assign w_clip = relu_en && w_sum[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_relu
            assign w_result[gi] = w_sum[gi] & ~w_clip;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (adder_valid) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
            r_acc   <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= '0;
        end else if (w_done) begin
            r_pix <= (r_pix == P_LAST) ? '0 : r_pix + 1'b1;
        end
    end

    // A completed result that finds the register full and stalled is dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_out_last  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done && w_can_load) begin
                r_out_valid <= 1'b1;
                r_dout      <= w_result;
                r_out_last  <= (r_pix == P_LAST);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_done && !w_can_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign out_last  = r_out_last;
    assign overrun   = r_overrun;
    assign in_ready  = !r_out_valid || out_ready;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Bench for conv_channel_accumulator: a 3-channel and a 1-channel instance, both with
// 4-pixel frames, checked against a pixel-level reference model plus directed constants.
module tb_conv_channel_accumulator;

    localparam int W   = 32;
    localparam int IC0 = 3;
    localparam int IC1 = 1;
    localparam int OP  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         av    [2];
    logic [W-1:0] din   [2];
    logic [W-1:0] bias  [2];
    logic         relu  [2];
    logic         rdy   [2];
    logic         ov    [2];
    logic [W-1:0] dout  [2];
    logic         ol    [2];
    logic         ir    [2];
    logic         orun  [2];

    always #5 clk = ~clk;

    conv_channel_accumulator #(.WIDTH(W), .IN_CHANNELS(IC0), .OUT_PIXELS(OP)) dut3 (
        .clk(clk), .rst(rst), .adder_valid(av[0]), .din(din[0]), .bias(bias[0]),
        .relu_en(relu[0]), .out_ready(rdy[0]), .out_valid(ov[0]), .dout(dout[0]),
        .out_last(ol[0]), .in_ready(ir[0]), .overrun(orun[0]));

    conv_channel_accumulator #(.WIDTH(W), .IN_CHANNELS(IC1), .OUT_PIXELS(OP)) dut1 (
        .clk(clk), .rst(rst), .adder_valid(av[1]), .din(din[1]), .bias(bias[1]),
        .relu_en(relu[1]), .out_ready(rdy[1]), .out_valid(ov[1]), .dout(dout[1]),
        .out_last(ol[1]), .in_ready(ir[1]), .overrun(orun[1]));

    // Reference model: pixel = first-beat bias + sum of its dins, then ReLU, then the
    // holding register with drop-on-stall semantics.
    bit           m_valid  [2];
    bit           m_last   [2];
    bit           m_ovr    [2];
    bit           m_loaded [2];
    logic [W-1:0] m_dout   [2];
    logic [W-1:0] m_fb     [2];
    logic [W-1:0] m_tot    [2];
    int           m_n      [2];
    int           m_pix    [2];
    int           res_cnt;
    bit           frame_mode;
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mstep(input int k, input int ic);
        bit           vo;
        logic [W-1:0] res;
        m_loaded[k] = 1'b0;
        if (rst) begin
            m_valid[k] = 1'b0; m_last[k] = 1'b0; m_ovr[k] = 1'b0; m_dout[k] = '0;
            m_n[k] = 0; m_pix[k] = 0; m_tot[k] = '0; m_fb[k] = '0;
            return;
        end
        vo = m_valid[k];
        if (vo && rdy[k]) m_valid[k] = 1'b0;
        if (av[k]) begin
            if (m_n[k] == 0) begin
                m_fb[k]  = bias[k];
                m_tot[k] = '0;
            end
            m_tot[k] = m_tot[k] + din[k];
            m_n[k]++;
            if (m_n[k] == ic) begin
                res = m_fb[k] + m_tot[k];
                if (relu[k] && $signed(res) < 0) res = '0;
                if (!vo || rdy[k]) begin
                    m_valid[k]  = 1'b1;
                    m_dout[k]   = res;
                    m_last[k]   = (m_pix[k] == OP - 1);
                    m_loaded[k] = 1'b1;
                end else begin
                    m_ovr[k] = 1'b1;
                end
                m_pix[k] = (m_pix[k] + 1) % OP;
                m_n[k]   = 0;
            end
        end
    endtask

    task automatic tick();
        mstep(0, IC0);
        mstep(1, IC1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid%0d", k), ov[k], m_valid[k]);
            chk($sformatf("dout%0d", k), dout[k], m_dout[k]);
            chk($sformatf("overrun%0d", k), orun[k], m_ovr[k]);
            chk($sformatf("in_ready%0d", k), ir[k], !m_valid[k] || rdy[k]);
            if (m_valid[k]) chk($sformatf("last%0d", k), ol[k], m_last[k]);
            if (m_loaded[k]) $display("txn dut%0d dout=%h last=%0d", k, dout[k], ol[k]);
        end
        if (m_loaded[0]) begin
            res_cnt++;
            if (frame_mode) chk("frame_last", ol[0], (res_cnt % 4) == 0);
        end
    endtask

    task automatic idle(input int n);
        av[0] = 1'b0; av[1] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic beat(input int k, input logic [W-1:0] b, input logic [W-1:0] d,
                        input logic re, input logic rd);
        av[0] = 1'b0; av[1] = 1'b0;
        av[k] = 1'b1; bias[k] = b; din[k] = d; relu[k] = re; rdy[k] = rd;
        tick();
        av[k] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; res_cnt = 0; frame_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            av[k] = 1'b0; din[k] = '0; bias[k] = '0; relu[k] = 1'b0; rdy[k] = 1'b1;
        end
        do_reset(2);
        chk("rst_valid", ov[0], 1'b0);
        chk("rst_dout", dout[0], '0);

        // Reset abandons a partial pixel; the next 3 beats form a fresh one.
        beat(0, 32'd99, 32'd1, 1'b0, 1'b1);
        do_reset(2);
        chk("rst_mid_valid", ov[0], 1'b0);
        chk("rst_mid_ovr", orun[0], 1'b0);
        beat(0, 32'd10, 32'd5, 1'b0, 1'b1);
        beat(0, 32'd0, 32'd7, 1'b0, 1'b1);
        beat(0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        chk("basic_dout", dout[0], 32'd20);
        chk("basic_valid", ov[0], 1'b1);
        idle(1);
        chk("basic_pulse", ov[0], 1'b0);

        beat(0, 32'd0, 32'hFFFF_FFFC, 1'b1, 1'b1);
        beat(0, 32'd0, 32'd1, 1'b1, 1'b1);
        beat(0, 32'd0, 32'd1, 1'b1, 1'b1);
        chk("relu_on", dout[0], 32'd0);
        beat(0, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
        beat(0, 32'd0, 32'd1, 1'b0, 1'b1);
        beat(0, 32'd0, 32'd1, 1'b0, 1'b1);
        chk("relu_off", dout[0], 32'hFFFF_FFFE);
        beat(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        beat(0, 32'd0, 32'd0, 1'b0, 1'b1);
        beat(0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("wrap", dout[0], 32'h8000_0000);
        idle(1);

        // Overrun: A held under backpressure, B dropped.
        beat(0, 32'd10, 32'd5, 1'b0, 1'b0);
        beat(0, 32'd0, 32'd7, 1'b0, 1'b0);
        beat(0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(0, 32'd0, 32'd1, 1'b0, 1'b0);
        chk("ovr_hold", dout[0], 32'd20);
        chk("ovr_flag", orun[0], 1'b1);
        rdy[0] = 1'b1;
        idle(2);
        chk("ovr_drain", ov[0], 1'b0);
        chk("ovr_sticky", orun[0], 1'b1);
        do_reset(1);
        chk("ovr_clear", orun[0], 1'b0);

        // Same-edge accept and load.
        beat(0, 32'd10, 32'd5, 1'b0, 1'b0);
        beat(0, 32'd0, 32'd7, 1'b0, 1'b0);
        beat(0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        beat(0, 32'd0, 32'd1, 1'b0, 1'b0);
        beat(0, 32'd0, 32'd1, 1'b0, 1'b0);
        beat(0, 32'd0, 32'd1, 1'b0, 1'b1);
        chk("same_edge_dout", dout[0], 32'd3);
        chk("same_edge_valid", ov[0], 1'b1);
        chk("same_edge_ovr", orun[0], 1'b0);
        idle(1);

        // Frame alignment with random idle gaps.
        do_reset(1);
        res_cnt = 0;
        frame_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < IC0; c++) begin
                beat(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
                idle($urandom_range(0, 3));
            end
        end
        idle(1);
        frame_mode = 1'b0;
        chk("frame_count", res_cnt, 8);

        // Single-channel instance: every beat completes a pixel.
        for (int i = 0; i < 3; i++) begin
            beat(1, 32'd3, 32'd4, 1'b0, 1'b1);
            chk("ic1_dout", dout[1], 32'd7);
            chk("ic1_valid", ov[1], 1'b1);
        end
        idle(1);

        // Random soak on both instances, including backpressure and overruns.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                av[k]   = 1'($urandom_range(0, 1));
                din[k]  = $urandom;
                bias[k] = $urandom;
                relu[k] = 1'($urandom_range(0, 1));
                rdy[k]  = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        do_reset(1);
        chk("final_rst_ovr", orun[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
